// File: rtl/save_fifo.sv
// Circular buffer between the controller's save and display phases.
// Registered pop data, occupancy count, and sticky misuse flags.
module save_fifo #(
    parameter int DATA_WIDTH = 8,
    parameter int DEPTH      = 8
) (
    input  logic                       clk,
    input  logic                       reset_n,
    input  logic                       clear,
    input  logic                       write_enable,
    input  logic [DATA_WIDTH-1:0]      write_data,
    input  logic                       read_enable,
    output logic [DATA_WIDTH-1:0]      read_data,
    output logic                       read_valid,
    output logic                       empty,
    output logic                       full,
    output logic [$clog2(DEPTH):0]     count,
    output logic                       overflow,
    output logic                       underflow
);

    localparam int ADDR_WIDTH = $clog2(DEPTH);
    localparam logic [ADDR_WIDTH:0] FULL_COUNT = (ADDR_WIDTH + 1)'(DEPTH);

    logic [DATA_WIDTH-1:0] mem [DEPTH];
    logic [ADDR_WIDTH-1:0] wr_ptr;
    logic [ADDR_WIDTH-1:0] rd_ptr;
    logic                  do_wr;
    logic                  do_rd;

    assign empty = (count == '0);
    assign full  = (count == FULL_COUNT);

    // Decisions use pre-edge status: a same-cycle read never frees room for a write
    assign do_wr = write_enable && !full;
    assign do_rd = read_enable && !empty;

    always_ff @(posedge clk) begin
        if (do_wr && !clear) begin
            mem[wr_ptr] <= write_data;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            wr_ptr     <= '0;
            rd_ptr     <= '0;
            count      <= '0;
            read_data  <= '0;
            read_valid <= 1'b0;
            overflow   <= 1'b0;
            underflow  <= 1'b0;
        end else if (clear) begin
            wr_ptr     <= '0;
            rd_ptr     <= '0;
            count      <= '0;
            read_data  <= '0;
            read_valid <= 1'b0;
            overflow   <= 1'b0;
            underflow  <= 1'b0;
        end else begin
            read_valid <= do_rd;
            if (do_wr) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (do_rd) begin
                read_data <= mem[rd_ptr];
                rd_ptr    <= rd_ptr + 1'b1;
            end
            if (do_wr && !do_rd) begin
                count <= count + 1'b1;
            end else if (do_rd && !do_wr) begin
                count <= count - 1'b1;
            end
            if (write_enable && full) begin
                overflow <= 1'b1;
            end
            if (read_enable && empty) begin
                underflow <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_save_fifo.sv
// Directed bench for save_fifo: reset, fill/drain, overflow, underflow,
// wrap-around and clear priority, all with hand-computed expectations.
module tb_save_fifo;

    logic       clk = 1'b0;
    logic       reset_n;
    logic       clear;
    logic       write_enable;
    logic [7:0] write_data;
    logic       read_enable;
    logic [7:0] read_data;
    logic       read_valid;
    logic       empty;
    logic       full;
    logic [3:0] count;
    logic       overflow;
    logic       underflow;

    int n_checks = 0;
    int n_pass   = 0;
    int max_count;

    save_fifo #(.DATA_WIDTH(8), .DEPTH(8)) dut (
        .clk          (clk),
        .reset_n      (reset_n),
        .clear        (clear),
        .write_enable (write_enable),
        .write_data   (write_data),
        .read_enable  (read_enable),
        .read_data    (read_data),
        .read_valid   (read_valid),
        .empty        (empty),
        .full         (full),
        .count        (count),
        .overflow     (overflow),
        .underflow    (underflow)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
        end else begin
            n_pass++;
        end
    endtask

    // One clock: drive strobes, take the edge, sample 1 time unit later
    task automatic step(input logic we, input logic [7:0] wd, input logic re, input logic clr);
        write_enable = we;
        write_data   = wd;
        read_enable  = re;
        clear        = clr;
        @(posedge clk);
        #1;
        write_enable = 1'b0;
        read_enable  = 1'b0;
        clear        = 1'b0;
    endtask

    task automatic check_reset_state(input string tag);
        check({tag, "_empty"},     empty,      1);
        check({tag, "_full"},      full,       0);
        check({tag, "_count"},     count,      0);
        check({tag, "_rdata"},     read_data,  0);
        check({tag, "_rvalid"},    read_valid, 0);
        check({tag, "_overflow"},  overflow,   0);
        check({tag, "_underflow"}, underflow,  0);
    endtask

    initial begin
        reset_n      = 1'b0;
        clear        = 1'b0;
        write_enable = 1'b0;
        write_data   = 8'h00;
        read_enable  = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        check_reset_state("por");
        @(negedge clk);
        reset_n = 1'b1;
        @(posedge clk);
        #1;

        // 1. mid-stream asynchronous reset
        step(1, 8'h3C, 0, 0);
        step(1, 8'h4D, 0, 0);
        step(0, 8'h00, 1, 0);
        step(0, 8'h00, 1, 0);
        step(0, 8'h00, 1, 0);
        check("pre_rst_rdata", read_data, 8'h4D);
        check("pre_rst_underflow", underflow, 1);
        step(1, 8'h5E, 0, 0);
        #2;
        reset_n = 1'b0;
        #1;
        check_reset_state("async_rst");
        @(negedge clk);
        reset_n = 1'b1;
        step(1, 8'h6F, 0, 0);
        check("first_op_count", count, 1);
        step(0, 8'h00, 1, 0);
        check("first_op_rdata", read_data, 8'h6F);
        check("first_op_empty", empty, 1);

        // 2. fill then drain
        for (int i = 0; i < 8; i++) begin
            step(1, 8'(8'h11 * (i + 1)), 0, 0);
            check("fill_count", count, i + 1);
            check("fill_full", full, (i == 7) ? 1 : 0);
        end
        for (int i = 0; i < 8; i++) begin
            step(0, 8'h00, 1, 0);
            check("drain_rdata", read_data, 8'h11 * (i + 1));
            check("drain_rvalid", read_valid, 1);
            check("drain_count", count, 7 - i);
        end
        check("drain_empty", empty, 1);
        step(0, 8'h00, 0, 0);
        check("idle_rvalid", read_valid, 0);
        check("idle_rdata_hold", read_data, 8'h88);

        // 3. overflow
        for (int i = 0; i < 8; i++) step(1, 8'(8'h11 * (i + 1)), 0, 0);
        check("ovf_pre_flag", overflow, 0);
        step(1, 8'hFF, 0, 0);
        check("ovf_count", count, 8);
        check("ovf_flag", overflow, 1);
        check("ovf_full", full, 1);
        for (int i = 0; i < 8; i++) begin
            step(0, 8'h00, 1, 0);
            check("ovf_drain_rdata", read_data, 8'h11 * (i + 1));
        end
        check("ovf_drain_empty", empty, 1);
        check("ovf_sticky", overflow, 1);

        // 4. underflow, then write+read on empty
        step(0, 8'h00, 1, 0);
        check("unf_rvalid", read_valid, 0);
        check("unf_rdata_hold", read_data, 8'h88);
        check("unf_flag", underflow, 1);
        step(1, 8'h5A, 1, 0);
        check("unf_wr_count", count, 1);
        check("unf_wr_rvalid", read_valid, 0);
        check("unf_wr_rdata", read_data, 8'h88);
        step(0, 8'h00, 1, 0);
        check("unf_next_rdata", read_data, 8'h5A);
        check("unf_next_rvalid", read_valid, 1);

        // 5. wrap-around; strobes stay high across consecutive steps
        step(0, 8'h00, 0, 1);
        check("clr_overflow", overflow, 0);
        check("clr_underflow", underflow, 0);
        max_count = 0;
        for (int i = 0; i < 5; i++) step(1, 8'(8'hC0 + i), 0, 0);
        check("wrap_five", count, 5);
        for (int i = 0; i < 5; i++) begin
            step(0, 8'h00, 1, 0);
            check("wrap_first_rdata", read_data, 8'hC0 + i);
        end
        for (int i = 0; i < 6; i++) begin
            step(1, 8'(8'hA0 + i), 0, 0);
            if (int'(count) > max_count) max_count = int'(count);
        end
        for (int i = 0; i < 6; i++) begin
            step(0, 8'h00, 1, 0);
            if (int'(count) > max_count) max_count = int'(count);
            check("wrap_rdata", read_data, 8'hA0 + i);
        end
        check("wrap_max_count", max_count, 6);
        check("wrap_empty", empty, 1);

        // full + simultaneous write & read: read wins, write rejected
        for (int i = 0; i < 8; i++) step(1, 8'(8'h21 + i), 0, 0);
        step(1, 8'hEE, 1, 0);
        check("full_wr_rd_count", count, 7);
        check("full_wr_rd_rdata", read_data, 8'h21);
        check("full_wr_rd_ovf", overflow, 1);

        // 6. clear priority
        step(0, 8'h00, 0, 1);
        step(0, 8'h00, 1, 0);
        check("clr6_unf_set", underflow, 1);
        step(1, 8'h01, 0, 0);
        step(1, 8'h02, 0, 0);
        step(1, 8'h03, 0, 0);
        check("clr6_count3", count, 3);
        step(1, 8'h99, 1, 1);
        check("clr6_count", count, 0);
        check("clr6_empty", empty, 1);
        check("clr6_rvalid", read_valid, 0);
        check("clr6_rdata", read_data, 0);
        check("clr6_overflow", overflow, 0);
        check("clr6_underflow", underflow, 0);
        step(1, 8'h77, 0, 0);
        step(0, 8'h00, 1, 0);
        check("clr6_new_rdata", read_data, 8'h77);
        check("clr6_new_rvalid", read_valid, 1);
        check("clr6_new_empty", empty, 1);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
